// File: rtl/mult_acc_pipe.sv
// Pipelined multiply-accumulate over tagged sample groups, with clock-enable stall.
// Define MULT_ACC_SAT_EN to saturate the group accumulator instead of wrapping.
module mult_acc_pipe #(
    parameter int ASIZE       = 16,
    parameter int BSIZE       = 16,
    parameter int A_SIGNED    = 0,
    parameter int B_SIGNED    = 0,
    parameter int PIPE_STAGES = 3,
    parameter int ACC_SIZE    = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [ASIZE-1:0]         a,
    input  logic [BSIZE-1:0]         b,
    output logic [ASIZE+BSIZE-1:0]   p,
    output logic                     p_valid,
    output logic [ACC_SIZE-1:0]      acc,
    output logic                     acc_valid,
    output logic                     acc_ovf
);
    localparam int PW       = ASIZE + BSIZE;
    localparam int AW       = ACC_SIZE;
    localparam bit P_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

    logic [PW-1:0] w_a_ext;
    logic [PW-1:0] w_b_ext;
    logic [PW-1:0] w_prod;

    // Extending both operands to the full product width makes one modular multiply exact for any sign mix.
    always_comb begin
        w_a_ext            = {PW{(A_SIGNED != 0) && a[ASIZE-1]}};
        w_a_ext[ASIZE-1:0] = a;
        w_b_ext            = {PW{(B_SIGNED != 0) && b[BSIZE-1]}};
        w_b_ext[BSIZE-1:0] = b;
        w_prod             = w_a_ext * w_b_ext;
    end

    logic [PW-1:0]          r_pipe_p [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] r_pipe_v;
    logic [PIPE_STAGES-1:0] r_pipe_f;
    logic [PIPE_STAGES-1:0] r_pipe_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                r_pipe_p[i] <= '0;
            end
            r_pipe_v <= '0;
            r_pipe_f <= '0;
            r_pipe_l <= '0;
        end else if (ce) begin
            r_pipe_p[0] <= w_prod;
            r_pipe_v[0] <= in_valid;
            r_pipe_f[0] <= in_first;
            r_pipe_l[0] <= in_last;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                r_pipe_p[i] <= r_pipe_p[i-1];
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_f[i] <= r_pipe_f[i-1];
                r_pipe_l[i] <= r_pipe_l[i-1];
            end
        end
    end

    logic [PW-1:0] w_p;
    logic          w_pv;
    logic          w_pf;
    logic          w_pl;

    assign w_p     = r_pipe_p[PIPE_STAGES-1];
    assign w_pv    = r_pipe_v[PIPE_STAGES-1];
    assign w_pf    = r_pipe_f[PIPE_STAGES-1];
    assign w_pl    = r_pipe_l[PIPE_STAGES-1];
    assign p       = w_p;
    assign p_valid = w_pv;

    logic [AW-1:0] r_run;
    logic          r_ovf;
    logic [AW-1:0] w_pext;
    logic [AW-1:0] w_base;
    logic [AW:0]   w_sum_full;
    logic [AW-1:0] w_sum;
    logic [AW-1:0] w_run_next;
    logic          w_ovf_prev;
    logic          w_ovf_step;
    logic          w_ovf_next;

    // A first-tagged sample restarts from zero, so its own add can never overflow.
    always_comb begin
        w_pext         = {AW{P_SIGNED && w_p[PW-1]}};
        w_pext[PW-1:0] = w_p;
        w_base         = w_pf ? '0 : r_run;
        w_ovf_prev     = w_pf ? 1'b0 : r_ovf;
        w_sum_full     = {1'b0, w_base} + {1'b0, w_pext};
        w_sum          = w_sum_full[AW-1:0];
        if (P_SIGNED) begin
            w_ovf_step = (w_base[AW-1] == w_pext[AW-1]) && (w_sum[AW-1] != w_base[AW-1]);
        end else begin
            w_ovf_step = w_sum_full[AW];
        end
        w_ovf_next = w_ovf_prev || w_ovf_step;
`ifdef MULT_ACC_SAT_EN
        if (w_ovf_prev) begin
            w_run_next = r_run;
        end else if (w_ovf_step) begin
            if (!P_SIGNED) begin
                w_run_next = '1;
            end else if (w_pext[AW-1]) begin
                w_run_next = {1'b1, {(AW-1){1'b0}}};
            end else begin
                w_run_next = {1'b0, {(AW-1){1'b1}}};
            end
        end else begin
            w_run_next = w_sum;
        end
`else
        w_run_next = w_sum;
`endif
    end

    logic [AW-1:0] r_acc;
    logic          r_acc_valid;
    logic          r_acc_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run       <= '0;
            r_ovf       <= 1'b0;
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
            r_acc_ovf   <= 1'b0;
        end else if (ce) begin
            r_acc_valid <= w_pv && w_pl;
            if (w_pv) begin
                r_run <= w_run_next;
                if (w_pl) begin
                    r_acc     <= w_run_next;
                    r_acc_ovf <= w_ovf_next;
                    r_ovf     <= 1'b0;
                end else begin
                    r_ovf <= w_ovf_next;
                end
            end
        end
    end

    assign acc       = r_acc;
    assign acc_valid = r_acc_valid;
    assign acc_ovf   = r_acc_ovf;

endmodule
